// File: rtl/cs_address_sequencer_pkg.sv
// Shared constants for the control-store address sequencer: COND encodings,
// FSM state encoding, PSR flag bit positions and default trap/timeout values.
package cs_address_sequencer_pkg;

    localparam int unsigned COND_W = 3;

    localparam logic [COND_W-1:0] COND_NEXT   = 3'b000;
    localparam logic [COND_W-1:0] COND_N      = 3'b001;
    localparam logic [COND_W-1:0] COND_Z      = 3'b010;
    localparam logic [COND_W-1:0] COND_V      = 3'b011;
    localparam logic [COND_W-1:0] COND_C      = 3'b100;
    localparam logic [COND_W-1:0] COND_IR13   = 3'b101;
    localparam logic [COND_W-1:0] COND_ALWAYS = 3'b110;
    localparam logic [COND_W-1:0] COND_DECODE = 3'b111;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_WAIT_MEM = 1'b1;

    // Bit positions inside the {n,z,v,c} flag nibble
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

    localparam int unsigned DEFAULT_WAIT_TIMEOUT = 16;
    localparam logic [10:0] DEFAULT_TRAP_ADDRESS = 11'h7FF;

endpackage

// File: rtl/cs_next_address_mux.sv
// Combinational next control-store address selection from the MIR COND field,
// the latched PSR flags and the current instruction.
module cs_next_address_mux
    import cs_address_sequencer_pkg::*;
#(
    parameter int unsigned AW  = 11,
    parameter int unsigned CW  = 3,
    parameter int unsigned IRW = 32
) (
    input  logic [CW-1:0]     cond,
    input  logic [AW-1:0]     jump_address,
    input  logic [IRW-1:0]    ir,
    input  logic [FLAG_W-1:0] flags,
    input  logic [AW-1:0]     csar,
    output logic [AW-1:0]     next_address_c
);

    logic [AW-1:0] incr_c;
    logic [AW-1:0] decode_c;
    logic          take_c;

    assign incr_c   = csar + AW'(1);
    // Decode target: 1, op, op3, 00
    assign decode_c = AW'({1'b1, ir[31:30], ir[24:19], 2'b00});

    always_comb begin
        take_c         = 1'b0;
        next_address_c = incr_c;
        case (cond)
            COND_NEXT:   take_c = 1'b0;
            COND_N:      take_c = flags[FLAG_N];
            COND_Z:      take_c = flags[FLAG_Z];
            COND_V:      take_c = flags[FLAG_V];
            COND_C:      take_c = flags[FLAG_C];
            COND_IR13:   take_c = ir[13];
            COND_ALWAYS: take_c = 1'b1;
            default:     take_c = 1'b0;
        endcase
        if (cond == COND_DECODE) begin
            next_address_c = decode_c;
        end else if (take_c) begin
            next_address_c = jump_address;
        end
    end

endmodule

// File: rtl/cs_address_sequencer.sv
// Microcode sequencer: CSAR register, PSR flag latch and RUN/WAIT_MEM FSM
// that stalls on unacknowledged memory requests and traps on timeout.
module cs_address_sequencer
    import cs_address_sequencer_pkg::*;
#(
    parameter int unsigned DATAWIDTH_JUMPADDRESS = 11,
    parameter int unsigned DATAWIDTH_CONDITION   = 3,
    parameter int unsigned DATAWIDTH_IR          = 32,
    parameter int unsigned WAIT_TIMEOUT          = DEFAULT_WAIT_TIMEOUT,
    parameter logic [DATAWIDTH_JUMPADDRESS-1:0] TRAP_ADDRESS =
        DATAWIDTH_JUMPADDRESS'(DEFAULT_TRAP_ADDRESS)
) (
    input  logic                             CS_ADDRESS_SEQUENCER_CLOCK_50,
    input  logic                             CS_ADDRESS_SEQUENCER_ResetInLow_In,
    input  logic [DATAWIDTH_CONDITION-1:0]   CS_ADDRESS_SEQUENCER_Condition_InBus,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_JumpAddress_InBus,
    input  logic [DATAWIDTH_IR-1:0]          CS_ADDRESS_SEQUENCER_IR_InBus,
    input  logic [FLAG_W-1:0]                CS_ADDRESS_SEQUENCER_Flags_InBus,
    input  logic                             CS_ADDRESS_SEQUENCER_FlagWrite_In,
    input  logic                             CS_ADDRESS_SEQUENCER_MemRequest_In,
    input  logic                             CS_ADDRESS_SEQUENCER_MemAck_In,
    output logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_CSAddress_OutBus,
    output logic [FLAG_W-1:0]                CS_ADDRESS_SEQUENCER_Flags_OutBus,
    output logic                             CS_ADDRESS_SEQUENCER_Stall_Out,
    output logic                             CS_ADDRESS_SEQUENCER_Error_Out
);

    localparam int unsigned AW    = DATAWIDTH_JUMPADDRESS;
    localparam int unsigned CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

    logic [0:0]        state_q, state_d;
    logic [AW-1:0]     csar_q, csar_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall_q, stall_d;
    logic              error_q, error_d;
    logic              advance_c;
    logic [AW-1:0]     next_address_c;

    cs_next_address_mux #(
        .AW  (AW),
        .CW  (DATAWIDTH_CONDITION),
        .IRW (DATAWIDTH_IR)
    ) u_next_address_mux (
        .cond           (CS_ADDRESS_SEQUENCER_Condition_InBus),
        .jump_address   (CS_ADDRESS_SEQUENCER_JumpAddress_InBus),
        .ir             (CS_ADDRESS_SEQUENCER_IR_InBus),
        .flags          (flags_q),
        .csar           (csar_q),
        .next_address_c (next_address_c)
    );

    // Next-state, counter, CSAR and flag-latch logic
    always_comb begin
        state_d   = state_q;
        csar_d    = csar_q;
        flags_d   = flags_q;
        cnt_d     = cnt_q;
        error_d   = 1'b0;
        advance_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (CS_ADDRESS_SEQUENCER_MemRequest_In && !CS_ADDRESS_SEQUENCER_MemAck_In) begin
                    state_d = ST_WAIT_MEM;
                    cnt_d   = '0;
                end else begin
                    advance_c = 1'b1;
                end
            end
            ST_WAIT_MEM: begin
                if (CS_ADDRESS_SEQUENCER_MemAck_In) begin
                    advance_c = 1'b1;
                    state_d   = ST_RUN;
                end else if (cnt_q == CNT_W'(WAIT_TIMEOUT - 1)) begin
                    csar_d  = TRAP_ADDRESS;
                    error_d = 1'b1;
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
        // Flags are written only when the microinstruction completes
        if (advance_c) begin
            csar_d = next_address_c;
            if (CS_ADDRESS_SEQUENCER_FlagWrite_In) begin
                flags_d = CS_ADDRESS_SEQUENCER_Flags_InBus;
            end
        end
        stall_d = (state_d == ST_WAIT_MEM);
    end

    always_ff @(posedge CS_ADDRESS_SEQUENCER_CLOCK_50) begin
        if (!CS_ADDRESS_SEQUENCER_ResetInLow_In) begin
            state_q <= ST_RUN;
            csar_q  <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            csar_q  <= csar_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            error_q <= error_d;
        end
    end

    assign CS_ADDRESS_SEQUENCER_CSAddress_OutBus = csar_q;
    assign CS_ADDRESS_SEQUENCER_Flags_OutBus     = flags_q;
    assign CS_ADDRESS_SEQUENCER_Stall_Out        = stall_q;
    assign CS_ADDRESS_SEQUENCER_Error_Out        = error_q;

endmodule
